// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: load-use bubbles, redirect flushes,
// memory-wait freeze with timeout, and saturating event counters.
module pipe_hazard_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rw,
  input  logic             ex_memtoreg,
  input  logic             ex_regwr,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_jump,
  input  logic             mem_memwr,
  input  logic             mem_memtoreg,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_redirect,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_write,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WMAX = WW'(WAIT_MAX);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [WW-1:0] wcnt;
  logic [WW-1:0] wcnt_nxt;

  logic mem_acc;
  logic taken;
  logic load_use;
  logic hold;
  logic lu_stall;
  logic redir;
  logic err_set;
  logic stall_inc;
  logic flush_inc;

  assign mem_acc  = mem_memwr | mem_memtoreg;
  assign taken    = (mem_branch & mem_zero) | mem_jump;
  assign load_use = ex_memtoreg & ex_regwr
                  & (ex_rw != 5'd0)
                  & ((ex_rw == id_rs) | (ex_rw == id_rt));

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    hold      = 1'b0;
    lu_stall  = 1'b0;
    redir     = 1'b0;
    err_set   = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (rst) begin
      state_nxt = RUN;
      wcnt_nxt  = '0;
      hold      = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          priority case (1'b1)
            mem_acc & ~dmem_ready: begin
              hold      = 1'b1;
              state_nxt = MEM_WAIT;
              wcnt_nxt  = WW'(1);
              stall_inc = 1'b1;
            end
            taken: begin
              redir     = 1'b1;
              flush_inc = 1'b1;
            end
            load_use: begin
              lu_stall  = 1'b1;
              stall_inc = 1'b1;
            end
            default: ;
          endcase
        end
        MEM_WAIT: begin
          // ready and timeout both release the pipeline for this cycle
          priority case (1'b1)
            dmem_ready: state_nxt = RUN;
            wcnt == WMAX: begin
              err_set   = 1'b1;
              state_nxt = RUN;
            end
            default: begin
              hold      = 1'b1;
              wcnt_nxt  = wcnt + WW'(1);
              stall_inc = 1'b1;
            end
          endcase
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign pc_write    = ~hold & ~lu_stall;
  assign ifid_write  = ~hold & ~lu_stall;
  assign idex_write  = ~hold;
  assign exmem_write = ~hold;
  assign memwb_write = ~hold;
  assign pc_redirect = redir;
  assign ifid_flush  = redir;
  assign idex_flush  = redir | lu_stall;
  assign exmem_flush = redir;
  assign dmem_req    = mem_acc & ~rst;

  always_ff @(posedge clk) begin
    state <= state_nxt;
    wcnt  <= wcnt_nxt;
    if (rst) begin
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (err_set)
        mem_err <= 1'b1;
      if (stall_inc && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int WMAX = 4;

  // {pc_write,pc_redirect,ifid_w,ifid_f,idex_w,idex_f,exmem_w,exmem_f,memwb_w,dmem_req}
  localparam logic [9:0] C_RST = 10'b0000000000;
  localparam logic [9:0] C_DEF = 10'b1010101010;
  localparam logic [9:0] C_LU  = 10'b0000111010;
  localparam logic [9:0] C_BR  = 10'b1111111110;
  localparam logic [9:0] C_FRZ = 10'b0000000001;
  localparam logic [9:0] C_REL = 10'b1010101011;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rw;
  logic ex_memtoreg, ex_regwr, mem_branch, mem_zero, mem_jump;
  logic mem_memwr, mem_memtoreg, dmem_ready;

  logic pc_write, pc_redirect, ifid_write, ifid_flush, idex_write;
  logic idex_flush, exmem_write, exmem_flush, memwb_write, dmem_req;
  logic mem_err;
  logic [15:0] stall_cnt, flush_cnt;

  logic pc_write2, pc_redirect2, ifid_write2, ifid_flush2, idex_write2;
  logic idex_flush2, exmem_write2, exmem_flush2, memwb_write2, dmem_req2;
  logic mem_err2;
  logic [1:0] stall_cnt2, flush_cnt2;

  wire [9:0] ctl = {pc_write, pc_redirect, ifid_write, ifid_flush,
    idex_write, idex_flush, exmem_write, exmem_flush, memwb_write, dmem_req};
  wire [9:0] ctl2 = {pc_write2, pc_redirect2, ifid_write2, ifid_flush2,
    idex_write2, idex_flush2, exmem_write2, exmem_flush2, memwb_write2,
    dmem_req2};

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.WAIT_MAX(WMAX), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rw(ex_rw),
    .ex_memtoreg(ex_memtoreg), .ex_regwr(ex_regwr),
    .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_jump(mem_jump),
    .mem_memwr(mem_memwr), .mem_memtoreg(mem_memtoreg),
    .dmem_ready(dmem_ready), .pc_write(pc_write),
    .pc_redirect(pc_redirect), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_write(idex_write),
    .idex_flush(idex_flush), .exmem_write(exmem_write),
    .exmem_flush(exmem_flush), .memwb_write(memwb_write),
    .dmem_req(dmem_req), .mem_err(mem_err), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.WAIT_MAX(WMAX), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rw(ex_rw),
    .ex_memtoreg(ex_memtoreg), .ex_regwr(ex_regwr),
    .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_jump(mem_jump),
    .mem_memwr(mem_memwr), .mem_memtoreg(mem_memtoreg),
    .dmem_ready(dmem_ready), .pc_write(pc_write2),
    .pc_redirect(pc_redirect2), .ifid_write(ifid_write2),
    .ifid_flush(ifid_flush2), .idex_write(idex_write2),
    .idex_flush(idex_flush2), .exmem_write(exmem_write2),
    .exmem_flush(exmem_flush2), .memwb_write(memwb_write2),
    .dmem_req(dmem_req2), .mem_err(mem_err2), .stall_cnt(stall_cnt2),
    .flush_cnt(flush_cnt2)
  );

  // reference model: pipeline waiting?, frozen cycles so far, events
  bit m_wait;
  int m_frozen;
  bit m_err;
  int m_stall;
  int m_flush;

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rw = 0;
    ex_memtoreg = 0; ex_regwr = 0;
    mem_branch = 0; mem_zero = 0; mem_jump = 0;
    mem_memwr = 0; mem_memtoreg = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic set_lu(input logic [4:0] rw);
    ex_memtoreg = 1; ex_regwr = 1; ex_rw = rw; id_rt = 5; id_rs = 9;
  endtask

  function automatic logic [9:0] exp_ctl();
    bit acc = mem_memwr | mem_memtoreg;
    bit tk = (mem_branch & mem_zero) | mem_jump;
    bit lu = ex_memtoreg && ex_regwr && ex_rw != 0 &&
             (ex_rw == id_rs || ex_rw == id_rt);
    logic [9:0] r;
    if (rst) return C_RST;
    if (m_wait)
      r = (dmem_ready || m_frozen >= WMAX) ? C_DEF : C_RST;
    else if (acc && !dmem_ready) r = C_RST;
    else if (tk) r = C_BR;
    else if (lu) r = C_LU;
    else r = C_DEF;
    r[0] = acc;
    return r;
  endfunction

  task automatic model_tick();
    bit acc = mem_memwr | mem_memtoreg;
    bit tk = (mem_branch & mem_zero) | mem_jump;
    bit lu = ex_memtoreg && ex_regwr && ex_rw != 0 &&
             (ex_rw == id_rs || ex_rw == id_rt);
    if (rst) begin
      m_wait = 0; m_frozen = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else if (m_wait) begin
      if (dmem_ready) m_wait = 0;
      else if (m_frozen >= WMAX) begin m_err = 1; m_wait = 0; end
      else begin m_frozen++; m_stall++; end
    end else if (acc && !dmem_ready) begin
      m_wait = 1; m_frozen = 1; m_stall++;
    end else if (tk) m_flush++;
    else if (lu) m_stall++;
  endtask

  task automatic test_reset();
    rst = 1; idle(); mem_memtoreg = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (ctl !== C_RST) begin bad++;
        $display("FAIL reset_ctl[%0d]: got %b want %b", i, ctl, C_RST); end
      @(posedge clk); #1;
    end
    total++; if (stall_cnt !== 0) begin bad++;
      $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    total++; if (flush_cnt !== 0) begin bad++;
      $display("FAIL reset_flush: got %0d want 0", flush_cnt); end
    total++; if (mem_err !== 0) begin bad++;
      $display("FAIL reset_err: got %b want 0", mem_err); end
    rst = 0; mem_memtoreg = 0;
    @(negedge clk);
    total++; if (ctl !== C_DEF) begin bad++;
      $display("FAIL reset_release: got %b want %b", ctl, C_DEF); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu(5);
    @(negedge clk);
    total++; if (ctl !== C_LU) begin bad++;
      $display("FAIL lu_ctl: got %b want %b", ctl, C_LU); end
    @(posedge clk); #1;
    total++; if (stall_cnt !== 1) begin bad++;
      $display("FAIL lu_stall: got %0d want 1", stall_cnt); end
    ex_rw = 0; id_rt = 0; id_rs = 0;
    @(negedge clk);
    total++; if (ctl !== C_DEF) begin bad++;
      $display("FAIL lu_r0_ctl: got %b want %b", ctl, C_DEF); end
    @(posedge clk); #1;
    total++; if (stall_cnt !== 1) begin bad++;
      $display("FAIL lu_r0_stall: got %0d want 1", stall_cnt); end
    ex_rw = 7; id_rs = 7; id_rt = 2;
    @(negedge clk);
    total++; if (ctl !== C_LU) begin bad++;
      $display("FAIL lu_rs_ctl: got %b want %b", ctl, C_LU); end
    @(posedge clk); #1;
    total++; if (stall_cnt !== 2) begin bad++;
      $display("FAIL lu_rs_stall: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_branch();
    do_reset();
    set_lu(5); mem_branch = 1; mem_zero = 1;
    @(negedge clk);
    total++; if (ctl !== C_BR) begin bad++;
      $display("FAIL br_ctl: got %b want %b", ctl, C_BR); end
    @(posedge clk); #1;
    total++; if (flush_cnt !== 1) begin bad++;
      $display("FAIL br_flush: got %0d want 1", flush_cnt); end
    total++; if (stall_cnt !== 0) begin bad++;
      $display("FAIL br_stall: got %0d want 0", stall_cnt); end
    mem_zero = 0;
    @(negedge clk);
    total++; if (ctl !== C_LU) begin bad++;
      $display("FAIL br_nt_ctl: got %b want %b", ctl, C_LU); end
    @(posedge clk); #1;
    idle(); mem_jump = 1;
    @(negedge clk);
    total++; if (ctl !== C_BR) begin bad++;
      $display("FAIL jmp_ctl: got %b want %b", ctl, C_BR); end
    @(posedge clk); #1;
    total++; if (flush_cnt !== 2) begin bad++;
      $display("FAIL jmp_flush: got %0d want 2", flush_cnt); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_memtoreg = 1; dmem_ready = 0; mem_jump = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (ctl !== C_FRZ) begin bad++;
        $display("FAIL wait_frz[%0d]: got %b want %b", i, ctl, C_FRZ); end
      @(posedge clk); #1;
    end
    dmem_ready = 1;
    @(negedge clk);
    total++; if (ctl !== C_REL) begin bad++;
      $display("FAIL wait_rel: got %b want %b", ctl, C_REL); end
    @(posedge clk); #1;
    total++; if (stall_cnt !== 3) begin bad++;
      $display("FAIL wait_stall: got %0d want 3", stall_cnt); end
    total++; if (flush_cnt !== 0) begin bad++;
      $display("FAIL wait_noflush: got %0d want 0", flush_cnt); end
    mem_memtoreg = 0; dmem_ready = 0;
    @(negedge clk);
    total++; if (ctl !== C_BR) begin bad++;
      $display("FAIL wait_deferred: got %b want %b", ctl, C_BR); end
    @(posedge clk); #1;
    total++; if (flush_cnt !== 1) begin bad++;
      $display("FAIL wait_def_flush: got %0d want 1", flush_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_memtoreg = 1; dmem_ready = 0;
    for (int i = 0; i < WMAX; i++) begin
      @(negedge clk);
      total++; if (ctl !== C_FRZ) begin bad++;
        $display("FAIL to_frz[%0d]: got %b want %b", i, ctl, C_FRZ); end
      @(posedge clk); #1;
      total++; if (mem_err !== 0) begin bad++;
        $display("FAIL to_early_err[%0d]: got %b want 0", i, mem_err); end
    end
    @(negedge clk);
    total++; if (ctl !== C_REL) begin bad++;
      $display("FAIL to_rel: got %b want %b", ctl, C_REL); end
    @(posedge clk); #1;
    total++; if (mem_err !== 1) begin bad++;
      $display("FAIL to_err: got %b want 1", mem_err); end
    total++; if (stall_cnt !== WMAX) begin bad++;
      $display("FAIL to_stall: got %0d want %0d", stall_cnt, WMAX); end
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (ctl !== C_DEF) begin bad++;
        $display("FAIL to_run[%0d]: got %b want %b", i, ctl, C_DEF); end
      @(posedge clk); #1;
      total++; if (mem_err !== 1) begin bad++;
        $display("FAIL to_sticky[%0d]: got %b want 1", i, mem_err); end
    end
    do_reset();
    total++; if (mem_err !== 0) begin bad++;
      $display("FAIL to_clear: got %b want 0", mem_err); end
  endtask

  task automatic test_rst_mid_wait();
    do_reset();
    mem_memwr = 1; dmem_ready = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1;
    @(negedge clk);
    total++; if (ctl !== C_RST) begin bad++;
      $display("FAIL rmw_ctl: got %b want %b", ctl, C_RST); end
    @(posedge clk); #1;
    total++; if (stall_cnt !== 0) begin bad++;
      $display("FAIL rmw_stall: got %0d want 0", stall_cnt); end
    rst = 0; idle();
    @(negedge clk);
    total++; if (ctl !== C_DEF) begin bad++;
      $display("FAIL rmw_run: got %b want %b", ctl, C_DEF); end
    @(posedge clk); #1;
    total++; if (mem_err !== 0) begin bad++;
      $display("FAIL rmw_err: got %b want 0", mem_err); end
  endtask

  task automatic test_saturation();
    do_reset();
    set_lu(5);
    repeat (5) begin @(posedge clk); #1; end
    total++; if (stall_cnt2 !== 2'd3) begin bad++;
      $display("FAIL sat_stall2: got %0d want 3", stall_cnt2); end
    total++; if (stall_cnt !== 5) begin bad++;
      $display("FAIL sat_stall16: got %0d want 5", stall_cnt); end
  endtask

  task automatic test_random();
    int drought = 0;
    logic [9:0] e;
    do_reset();
    m_wait = 0; m_frozen = 0; m_err = 0; m_stall = 0; m_flush = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rw = 5'($urandom_range(0, 3));
      ex_memtoreg = 1'($urandom);
      ex_regwr = 1'($urandom);
      mem_branch = 1'($urandom);
      mem_zero = 1'($urandom);
      mem_jump = ($urandom_range(0, 7) == 0);
      mem_memwr = ($urandom_range(0, 5) == 0);
      mem_memtoreg = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) drought = 7;
      if (drought > 0) begin dmem_ready = 0; drought--; end
      else dmem_ready = 1'($urandom);
      e = exp_ctl();
      @(negedge clk);
      total++; if (ctl !== e) begin bad++;
        $display("FAIL rnd_ctl[%0d]: got %b want %b", i, ctl, e); end
      total++; if (ctl2 !== e) begin bad++;
        $display("FAIL rnd_ctl2[%0d]: got %b want %b", i, ctl2, e); end
      @(posedge clk); #1;
      model_tick();
      total++; if (stall_cnt !== 16'(m_stall > 65535 ? 65535 : m_stall)) begin
        bad++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", i,
          stall_cnt, m_stall); end
      total++; if (flush_cnt !== 16'(m_flush > 65535 ? 65535 : m_flush)) begin
        bad++; $display("FAIL rnd_flush[%0d]: got %0d want %0d", i,
          flush_cnt, m_flush); end
      total++; if (stall_cnt2 !== 2'(m_stall > 3 ? 3 : m_stall)) begin
        bad++; $display("FAIL rnd_stall2[%0d]: got %0d want %0d", i,
          stall_cnt2, m_stall > 3 ? 3 : m_stall); end
      total++; if (flush_cnt2 !== 2'(m_flush > 3 ? 3 : m_flush)) begin
        bad++; $display("FAIL rnd_flush2[%0d]: got %0d want %0d", i,
          flush_cnt2, m_flush > 3 ? 3 : m_flush); end
      total++; if (mem_err !== m_err || mem_err2 !== m_err) begin
        bad++; $display("FAIL rnd_err[%0d]: got %b/%b want %b", i,
          mem_err, mem_err2, m_err); end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; idle();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_rst_mid_wait();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
